// File: rtl/reg_mem_fifo_ctrl.sv
// reg_mem_fifo_ctrl: FIFO controller wrapped around a single-ported reg_mem.
// The controller owns the memory address, write data and write enable. Words
// arrive on a valid/ready input stream, are written at a circular write
// pointer, read back at a circular read pointer and held in a registered
// output stage. Only one memory access (read or write) happens per cycle, and
// reads win over writes.
//
// Optional feature: define FIFO_STATS_EN to add an 8-bit saturating stall_cnt
// output that counts cycles with in_valid=1 while in_ready=0.

module reg_mem_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_wen,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic [ADDR_BITS:0]    count,
  output logic                  full,
`ifdef FIFO_STATS_EN
  output logic                  empty,
  output logic [7:0]            stall_cnt
`else
  output logic                  empty
`endif
);

  localparam int                DEPTH     = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS:0] DEPTH_CNT = (ADDR_BITS + 1)'(DEPTH);

  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic [ADDR_BITS:0]   mem_count;
  logic                 out_free;
  logic                 mem_has_data;
  logic                 mem_full;
  logic                 rd_go;
  logic                 wr_go;

  // Access arbitration: refill the output register first, accept input only
  // on cycles the memory port is idle. in_ready is also held low during reset
  // so no write reaches the memory while the controller is being cleared.
  always_comb begin
    out_free     = !out_valid || out_ready;
    mem_has_data = (mem_count != '0);
    mem_full     = (mem_count == DEPTH_CNT);
    rd_go        = out_free && mem_has_data;
    in_ready     = rst_n && !mem_full && !rd_go;
    wr_go        = in_valid && in_ready;
    mem_addr     = rd_go ? rd_ptr : wr_ptr;
    mem_wen      = wr_go;
    mem_data_in  = in_data;
  end

  // Occupancy flags; the output register counts as one extra slot.
  always_comb begin
    count = mem_count + {{ADDR_BITS{1'b0}}, out_valid};
    full  = mem_full;
    empty = (count == '0);
  end

  // Pointer and occupancy bookkeeping; pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_count <= '0;
    end else begin
      if (wr_go) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_go) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({wr_go, rd_go})
        2'b10:   mem_count <= mem_count + 1'b1;
        2'b01:   mem_count <= mem_count - 1'b1;
        default: mem_count <= mem_count;
      endcase
    end
  end

  // Output stage: load from memory on a read, otherwise drop valid once the
  // consumer has taken the word; data is left untouched when emptied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (rd_go) begin
      out_valid <= 1'b1;
      out_data  <= mem_data_out;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef FIFO_STATS_EN
  // Saturating count of cycles where the producer was held off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (in_valid && !in_ready && (stall_cnt != 8'hFF)) begin
      stall_cnt <= stall_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_reg_mem_fifo_ctrl.sv
// Self-checking bench for reg_mem_fifo_ctrl with a behavioural reg_mem model
// (combinational read, write on the rising edge when wen=1).

module tb_reg_mem_fifo_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] mem_addr;
  logic [7:0] mem_data_in;
  logic       mem_wen;
  logic [7:0] mem_data_out;
  logic [5:0] count;
  logic       full;
  logic       empty;
`ifdef FIFO_STATS_EN
  logic [7:0] stall_cnt;
`endif

  int n_compared   = 0;
  int n_mismatched = 0;

  reg_mem_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_BITS(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_wen      (mem_wen),
    .mem_data_out (mem_data_out),
    .count        (count),
    .full         (full),
`ifdef FIFO_STATS_EN
    .empty        (empty),
    .stall_cnt    (stall_cnt)
`else
    .empty        (empty)
`endif
  );

  // reg_mem model
  logic [7:0] mem [32];
  assign mem_data_out = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_wen) mem[mem_addr] <= mem_data_in;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("[TB] FAIL global_timeout: simulation did not finish, required finish before 300000");
    $fatal(1, "[TB] timeout");
  end

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       e_in_ready;
    logic       e_wen;
    logic [4:0] e_addr;
    logic       e_ov;
    logic [7:0] e_od;
    logic [5:0] e_cnt;
  } vec_t;

  vec_t vecs [8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 8'h00, 1'b0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int         accepted;
    int         cyc;
    int         sent;
    int         received;
    int         mem_cnt_m;
    logic       ov_m;
    logic       rd_m;
    logic       ir_m;
    logic       iv;
    logic       r;
    logic       took;
    logic [7:0] nxt;
    logic [7:0] want;
    logic [7:0] sb [$];

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;

    // iv id ordy | in_ready wen addr | after edge: ov od cnt
    vecs[0] = '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 8'h00, 6'd1};
    vecs[1] = '{1'b1, 8'hA2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 8'hA1, 6'd1};
    vecs[2] = '{1'b1, 8'hA2, 1'b0, 1'b1, 1'b1, 5'd1, 1'b1, 8'hA1, 6'd2};
    vecs[3] = '{1'b1, 8'hA3, 1'b1, 1'b0, 1'b0, 5'd1, 1'b1, 8'hA2, 6'd1};
    vecs[4] = '{1'b1, 8'hA3, 1'b1, 1'b1, 1'b1, 5'd2, 1'b0, 8'hA2, 6'd1};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd2, 1'b1, 8'hA3, 6'd1};
    vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd3, 1'b1, 8'hA3, 6'd1};
    vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 5'd3, 1'b0, 8'hA3, 6'd0};

    doReset();
    checkOutput("reset_count", count, 0);
    checkOutput("reset_empty", empty, 1);
    checkOutput("reset_full", full, 0);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out_data", out_data, 0);

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].iv, vecs[i].id, vecs[i].ordy);
      checkOutput($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].e_in_ready);
      checkOutput($sformatf("vec%0d_wen", i), mem_wen, vecs[i].e_wen);
      checkOutput($sformatf("vec%0d_addr", i), mem_addr, vecs[i].e_addr);
      checkOutput($sformatf("vec%0d_data_in", i), mem_data_in, vecs[i].id);
      tick();
      checkOutput($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].e_ov);
      if (vecs[i].e_ov) checkOutput($sformatf("vec%0d_out_data", i), out_data, vecs[i].e_od);
      checkOutput($sformatf("vec%0d_count", i), count, vecs[i].e_cnt);
    end

    // Asynchronous reset in the middle of a write burst
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 8'(8'h50 + i), 1'b0);
      tick();
    end
    applyStimulus(1'b1, 8'h60, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_out_valid", out_valid, 0);
    checkOutput("async_rst_count", count, 0);
    checkOutput("async_rst_empty", empty, 1);
    checkOutput("async_rst_full", full, 0);
    checkOutput("async_rst_wen", mem_wen, 0);
    checkOutput("async_rst_addr", mem_addr, 0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    tick();

    // Fill to DEPTH+1 words with the consumer stalled
    doReset();
    nxt      = 8'd10;
    accepted = 0;
    cyc      = 0;
    while (accepted < 33 && cyc < 200) begin
      applyStimulus(1'b1, nxt, 1'b0);
      if (cyc == 1) checkOutput("fill_prefetch_in_ready", in_ready, 0);
      took = in_ready;
      tick();
      if (took) begin
        nxt = nxt + 8'd1;
        accepted++;
      end
      cyc++;
    end
    checkOutput("fill_accepted", accepted, 33);
    applyStimulus(1'b1, nxt, 1'b0);
    checkOutput("fill_in_ready", in_ready, 0);
    checkOutput("fill_full", full, 1);
    checkOutput("fill_count", count, 33);
    checkOutput("fill_out_valid", out_valid, 1);
    checkOutput("fill_out_data", out_data, 10);
    tick();
    checkOutput("fill_hold_count", count, 33);

    // Drain: one word per cycle in order
    for (int i = 0; i < 33; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput($sformatf("drain%0d_valid", i), out_valid, 1);
      checkOutput($sformatf("drain%0d_data", i), out_data, 10 + i);
      tick();
    end
    checkOutput("drain_end_valid", out_valid, 0);
    checkOutput("drain_end_empty", empty, 1);

    // Random traffic with wrap-around and forced contention windows
    doReset();
    sb.delete();
    sent      = 0;
    received  = 0;
    mem_cnt_m = 0;
    ov_m      = 1'b0;
    cyc       = 0;
    while (received < 100 && cyc < 3000) begin
      if ((cyc % 100) < 30) begin
        iv = 1'b1;
        r  = 1'b1;
      end else begin
        iv = ($urandom_range(0, 99) < 60);
        r  = ($urandom_range(0, 99) < 55);
      end
      if (sent >= 100) iv = 1'b0;
      applyStimulus(iv, 8'(sent), r);
      rd_m = (!ov_m || r) && (mem_cnt_m != 0);
      ir_m = (mem_cnt_m != 32) && !rd_m;
      checkOutput("rnd_in_ready", in_ready, ir_m);
      checkOutput("rnd_wen", mem_wen, iv && ir_m);
      checkOutput("rnd_count", count, mem_cnt_m + int'(ov_m));
      checkOutput("rnd_out_valid", out_valid, ov_m);
      if (ov_m && r) begin
        if (sb.size() == 0) begin
          checkOutput("rnd_scoreboard_underflow", 1, 0);
        end else begin
          want = sb.pop_front();
          checkOutput("rnd_order", out_data, want);
        end
        received++;
      end
      if (iv && ir_m) begin
        sb.push_back(8'(sent));
        sent++;
      end
      tick();
      if (rd_m) ov_m = 1'b1;
      else if (r) ov_m = 1'b0;
      mem_cnt_m = mem_cnt_m + int'(iv && ir_m) - int'(rd_m);
      cyc++;
    end
    checkOutput("rnd_received", received, 100);
    checkOutput("rnd_sent", sent, 100);

`ifdef FIFO_STATS_EN
    // Stall counter saturation and clear
    doReset();
    checkOutput("stats_reset", stall_cnt, 0);
    for (int i = 0; i < 334; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0);
      tick();
    end
    checkOutput("stats_full", full, 1);
    checkOutput("stats_saturated", stall_cnt, 255);
    rst_n = 1'b0;
    #1;
    checkOutput("stats_cleared", stall_cnt, 0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
